// File: rtl/trg_mon_frame_tx.sv
// trg_mon_frame_tx
// Telemetry frame reader/transmitter for the trigger monitor register bank.
// A request raises a one-cycle snapshot strobe. The block then reads monitor
// words FIRST_ADDR..LAST_ADDR one at a time and streams a big-endian byte
// frame: HEADER, every word, then a 16-bit wrapping sum of the words.
//
// Ports:
//   clk_in        system clock
//   rst_in        synchronous active-high reset; aborts any frame in flight
//   tel_req_in    frame request, sampled only while idle
//   store_en_out  one-cycle snapshot strobe to the monitor bank
//   rd_out        one-cycle read strobe per word
//   rd_addr_out   monitor read address
//   mon_data_in   read data, valid the cycle after rd_out
//   tx_data_out   frame byte
//   tx_valid_out  tx_data_out valid
//   tx_ready_in   sink accepts a byte on an edge where valid & ready
//   busy_out      high from request acceptance until frame completion
//   done_out      one-cycle pulse after the last checksum byte is accepted
module trg_mon_frame_tx #(
  parameter logic [7:0]  FIRST_ADDR = 8'h02,
  parameter logic [7:0]  LAST_ADDR  = 8'h24,
  parameter logic [15:0] HEADER     = 16'hEB90
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tel_req_in,
  output logic        store_en_out,
  output logic        rd_out,
  output logic [7:0]  rd_addr_out,
  input  logic [15:0] mon_data_in,
  output logic [7:0]  tx_data_out,
  output logic        tx_valid_out,
  input  logic        tx_ready_in,
  output logic        busy_out,
  output logic        done_out
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SNAP,
    S_HDR_HI,
    S_HDR_LO,
    S_RD,
    S_CAP,
    S_D_HI,
    S_D_LO,
    S_CS_HI,
    S_CS_LO
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q;
  logic [15:0] word_q;
  logic [15:0] csum_q;
  logic        done_q;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: address counter, word capture, running checksum, done pulse
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_q <= FIRST_ADDR;
      word_q <= '0;
      csum_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == S_CS_LO) && tx_ready_in;
      case (state_q)
        S_IDLE: begin
          if (tel_req_in) begin
            addr_q <= FIRST_ADDR;
            csum_q <= '0;
          end
        end
        S_CAP: begin
          word_q <= mon_data_in;
          csum_q <= csum_q + mon_data_in;
        end
        S_D_LO: begin
          if (tx_ready_in && (addr_q != LAST_ADDR)) begin
            addr_q <= addr_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic; every byte state holds until its byte is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tel_req_in)  state_d = S_SNAP;
      S_SNAP:                    state_d = S_HDR_HI;
      S_HDR_HI: if (tx_ready_in) state_d = S_HDR_LO;
      S_HDR_LO: if (tx_ready_in) state_d = S_RD;
      S_RD:                      state_d = S_CAP;
      S_CAP:                     state_d = S_D_HI;
      S_D_HI:   if (tx_ready_in) state_d = S_D_LO;
      S_D_LO: begin
        if (tx_ready_in) begin
          state_d = (addr_q == LAST_ADDR) ? S_CS_HI : S_RD;
        end
      end
      S_CS_HI:  if (tx_ready_in) state_d = S_CS_LO;
      S_CS_LO:  if (tx_ready_in) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state only, so the presented byte cannot change
  // while the sink stalls.
  always_comb begin
    store_en_out = 1'b0;
    rd_out       = 1'b0;
    rd_addr_out  = addr_q;
    tx_valid_out = 1'b0;
    tx_data_out  = '0;
    busy_out     = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:   rd_addr_out = FIRST_ADDR;
      S_SNAP:   store_en_out = 1'b1;
      S_RD:     rd_out = 1'b1;
      S_HDR_HI: begin tx_valid_out = 1'b1; tx_data_out = HEADER[15:8]; end
      S_HDR_LO: begin tx_valid_out = 1'b1; tx_data_out = HEADER[7:0];  end
      S_D_HI:   begin tx_valid_out = 1'b1; tx_data_out = word_q[15:8]; end
      S_D_LO:   begin tx_valid_out = 1'b1; tx_data_out = word_q[7:0];  end
      S_CS_HI:  begin tx_valid_out = 1'b1; tx_data_out = csum_q[15:8]; end
      S_CS_LO:  begin tx_valid_out = 1'b1; tx_data_out = csum_q[7:0];  end
      default: ;
    endcase
  end

  assign done_out = done_q;

endmodule

// File: tb/tb_trg_mon_frame_tx.sv
module tb_trg_mon_frame_tx;

  logic        clk_in      = 1'b0;
  logic        rst_in      = 1'b1;
  logic        tel_req_in  = 1'b0;
  logic        tx_ready_in = 1'b0;
  logic [15:0] mon_data_in = '0;
  logic        store_en_out, rd_out, tx_valid_out, busy_out, done_out;
  logic [7:0]  rd_addr_out, tx_data_out;

  trg_mon_frame_tx #(
    .FIRST_ADDR(8'h02),
    .LAST_ADDR (8'h24),
    .HEADER    (16'hEB90)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .tel_req_in  (tel_req_in),
    .store_en_out(store_en_out),
    .rd_out      (rd_out),
    .rd_addr_out (rd_addr_out),
    .mon_data_in (mon_data_in),
    .tx_data_out (tx_data_out),
    .tx_valid_out(tx_valid_out),
    .tx_ready_in (tx_ready_in),
    .busy_out    (busy_out),
    .done_out    (done_out)
  );

  always #10 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc++;

  // Monitor bank: read data appears one cycle after rd_out, garbage otherwise.
  logic [15:0] bank [0:255];
  always @(posedge clk_in) mon_data_in <= rd_out ? bank[rd_addr_out] : 16'($urandom);

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Event log collected mid-cycle
  logic [7:0] byte_q[$];
  int         byte_cyc_q[$];
  logic [7:0] rd_addr_q[$];
  int         rd_cyc_q[$];
  int         store_cyc_q[$];
  int         done_cyc_q[$];
  int         stab_err = 0;
  int         ovl_err  = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;

  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!tx_valid_out || tx_data_out != prev_data)) stab_err++;
      prev_stall = tx_valid_out && !tx_ready_in;
      prev_data  = tx_data_out;
      if (tx_valid_out && tx_ready_in) begin
        byte_q.push_back(tx_data_out);
        byte_cyc_q.push_back(cyc);
      end
      if (rd_out) begin
        rd_addr_q.push_back(rd_addr_out);
        rd_cyc_q.push_back(cyc);
      end
      if (store_en_out) store_cyc_q.push_back(cyc);
      if (done_out) done_cyc_q.push_back(cyc);
      if ((rd_out && (store_en_out || tx_valid_out)) || (store_en_out && tx_valid_out)) ovl_err++;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_log();
    byte_q.delete(); byte_cyc_q.delete(); rd_addr_q.delete(); rd_cyc_q.delete();
    store_cyc_q.delete(); done_cyc_q.delete();
    stab_err = 0; ovl_err = 0;
  endtask

  function automatic bit pick(int duty);
    return int'($urandom_range(99)) < duty;
  endfunction

  // 0: zeros with 5AA5/EB90 in the last two words, 1: word=address,
  // 2: all FFFF, 3: random
  task automatic fill_bank(int pattern);
    for (int a = 0; a < 256; a++) begin
      case (pattern)
        0:       bank[a] = 16'h0000;
        1:       bank[a] = 16'(a);
        2:       bank[a] = 16'hFFFF;
        default: bank[a] = 16'($urandom);
      endcase
    end
    if (pattern == 0) begin
      bank[8'h23] = 16'h5AA5;
      bank[8'h24] = 16'hEB90;
    end
  endtask

  // Issue a request in the current cycle (cycle 0 = c0) and run until done.
  task automatic run_frame(input int duty, input bit hold, output int c0, output bit to);
    int  n;
    bit  held;
    clear_log();
    n    = 0;
    held = 1'b0;
    to   = 1'b0;
    tel_req_in  = 1'b1;
    c0          = cyc;
    tx_ready_in = pick(duty);
    tick();
    tel_req_in = 1'b0;
    while (done_cyc_q.size() == 0) begin
      // 23 bytes taken: the low byte of word 10 is on the bus
      if (hold && !held && byte_q.size() == 23 && tx_valid_out) begin
        int         r0;
        logic [7:0] d0;
        r0 = rd_cyc_q.size();
        d0 = tx_data_out;
        held = 1'b1;
        tx_ready_in = 1'b0;
        repeat (20) tick();
        chk("hold_rd_count", 32'(rd_cyc_q.size()), 32'(r0));
        chk("hold_data", 32'(tx_data_out), 32'(d0));
        chk("hold_valid", 32'(tx_valid_out), 32'd1);
      end
      tx_ready_in = pick(duty);
      tick();
      n++;
      if (n > 5000) begin
        to = 1'b1;
        break;
      end
    end
    tx_ready_in = 1'b0;
    if (hold) chk("hold_applied", 32'(held), 32'd1);
  endtask

  // Compare the logged frame with one built from the bank contents.
  task automatic check_frame(input int c0, input bit exact, input bit has_cs,
                             input logic [15:0] exp_cs, input string tag);
    logic [7:0]  exp[$];
    logic [15:0] sum;
    int          nb;
    sum = '0;
    exp.push_back(8'hEB);
    exp.push_back(8'h90);
    for (int a = 8'h02; a <= 8'h24; a++) begin
      exp.push_back(bank[a][15:8]);
      exp.push_back(bank[a][7:0]);
      sum = sum + bank[a];
    end
    exp.push_back(sum[15:8]);
    exp.push_back(sum[7:0]);

    chk({tag, " byte_count"}, 32'(byte_q.size()), 32'd74);
    nb = (byte_q.size() < 74) ? byte_q.size() : 74;
    for (int i = 0; i < nb; i++)
      chk($sformatf("%s byte[%0d]", tag, i), 32'(byte_q[i]), 32'(exp[i]));
    if (has_cs && byte_q.size() >= 74)
      chk({tag, " checksum"}, 32'({byte_q[72], byte_q[73]}), 32'(exp_cs));

    chk({tag, " rd_count"}, 32'(rd_addr_q.size()), 32'd35);
    for (int k = 0; k < rd_addr_q.size() && k < 35; k++)
      chk($sformatf("%s rd_addr[%0d]", tag, k), 32'(rd_addr_q[k]), 32'(k + 2));
    chk({tag, " done_count"}, 32'(done_cyc_q.size()), 32'd1);
    chk({tag, " store_count"}, 32'(store_cyc_q.size()), 32'd1);
    chk({tag, " stall_stability"}, 32'(stab_err), 32'd0);
    chk({tag, " strobe_overlap"}, 32'(ovl_err), 32'd0);

    if (exact) begin
      if (store_cyc_q.size() > 0) chk({tag, " store_cycle"}, 32'(store_cyc_q[0] - c0), 32'd1);
      if (done_cyc_q.size() > 0)  chk({tag, " done_cycle"}, 32'(done_cyc_q[0] - c0), 32'd146);
      for (int k = 0; k < rd_cyc_q.size() && k < 35; k++)
        chk($sformatf("%s rd_cycle[%0d]", tag, k), 32'(rd_cyc_q[k] - c0), 32'(4 + 4 * k));
      for (int i = 0; i < nb; i++) begin
        int e;
        if (i < 2)       e = 2 + i;
        else if (i < 72) e = 6 + 4 * ((i - 2) / 2) + ((i - 2) % 2);
        else             e = 144 + (i - 72);
        chk($sformatf("%s byte_cycle[%0d]", tag, i), 32'(byte_cyc_q[i] - c0), 32'(e));
      end
    end
  endtask

  typedef struct {
    int          pattern;
    int          duty;
    bit          hold;
    bit          exact;
    bit          has_cs;
    logic [15:0] cs;
    string       name;
  } vec_t;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    int   c0;
    bit   to;

    vecs.push_back('{0, 100, 1'b0, 1'b1, 1'b1, 16'h4635, "nominal"});
    vecs.push_back('{1, 100, 1'b0, 1'b1, 1'b1, 16'h0299, "addr_echo"});
    vecs.push_back('{2, 100, 1'b0, 1'b1, 1'b1, 16'hFFDD, "wrap"});
    vecs.push_back('{0,  30, 1'b1, 1'b0, 1'b1, 16'h4635, "backpressure"});
    vecs.push_back('{3, 100, 1'b0, 1'b1, 1'b0, 16'h0000, "rand_full"});
    vecs.push_back('{3,  30, 1'b0, 1'b0, 1'b0, 16'h0000, "rand_bp30"});
    vecs.push_back('{3,  60, 1'b1, 1'b0, 1'b0, 16'h0000, "rand_hold"});
    vecs.push_back('{3,  10, 1'b0, 1'b0, 1'b0, 16'h0000, "rand_bp10"});

    rst_in = 1'b1;
    repeat (3) tick();
    chk("rst store_en", 32'(store_en_out), 32'd0);
    chk("rst rd", 32'(rd_out), 32'd0);
    chk("rst rd_addr", 32'(rd_addr_out), 32'h02);
    chk("rst tx_data", 32'(tx_data_out), 32'd0);
    chk("rst tx_valid", 32'(tx_valid_out), 32'd0);
    chk("rst busy", 32'(busy_out), 32'd0);
    chk("rst done", 32'(done_out), 32'd0);
    rst_in = 1'b0;
    repeat (2) tick();

    foreach (vecs[v]) begin
      fill_bank(vecs[v].pattern);
      run_frame(vecs[v].duty, vecs[v].hold, c0, to);
      chk({vecs[v].name, " timeout"}, 32'(to), 32'd0);
      check_frame(c0, vecs[v].exact, vecs[v].has_cs, vecs[v].cs, vecs[v].name);
      chk({vecs[v].name, " idle_after"}, 32'(busy_out), 32'd0);
      repeat (3) tick();
    end

    // Request during busy is dropped; a request at cycle 146 starts frame two.
    fill_bank(0);
    clear_log();
    tx_ready_in = 1'b1;
    c0 = cyc;
    for (int r = 0; r <= 300; r++) begin
      tel_req_in = (r == 0 || r == 50 || r == 146);
      if (r == 50) chk("busy at 50", 32'(busy_out), 32'd1);
      if (r == 146) begin
        chk("busy at 146", 32'(busy_out), 32'd0);
        chk("done at 146", 32'(done_out), 32'd1);
      end
      tick();
    end
    tel_req_in  = 1'b0;
    tx_ready_in = 1'b0;
    chk("req2 store_count", 32'(store_cyc_q.size()), 32'd2);
    if (store_cyc_q.size() == 2) begin
      chk("req2 store0", 32'(store_cyc_q[0] - c0), 32'd1);
      chk("req2 store1", 32'(store_cyc_q[1] - c0), 32'd147);
    end
    chk("req2 done_count", 32'(done_cyc_q.size()), 32'd2);
    if (done_cyc_q.size() == 2) chk("req2 done1", 32'(done_cyc_q[1] - c0), 32'd292);
    chk("req2 byte_count", 32'(byte_q.size()), 32'd148);
    repeat (3) tick();

    // Reset mid-frame, then a clean frame with the checksum restarted.
    fill_bank(3);
    clear_log();
    tx_ready_in = 1'b1;
    for (int r = 0; r <= 60; r++) begin
      tel_req_in = (r == 0);
      rst_in     = (r == 60);
      tick();
    end
    rst_in = 1'b0;
    chk("midrst tx_valid", 32'(tx_valid_out), 32'd0);
    chk("midrst busy", 32'(busy_out), 32'd0);
    chk("midrst rd_addr", 32'(rd_addr_out), 32'h02);
    chk("midrst done", 32'(done_out), 32'd0);
    repeat (5) tick();
    chk("midrst no_done", 32'(done_cyc_q.size()), 32'd0);
    fill_bank(3);
    run_frame(100, 1'b0, c0, to);
    chk("after_rst timeout", 32'(to), 32'd0);
    check_frame(c0, 1'b1, 1'b0, 16'h0000, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
